// File: rtl/xtea_dec.sv
// ---------------------------------------------------------------------------
// xtea_dec
// Iterative XTEA decrypter. Two independent 64-bit blocks are decrypted in
// parallel under one shared 128-bit key. Each round takes three cycles: a
// Z-step, a SUM-step and a Y-step. The word packing of v and data_o matches
// the encrypter output, so ciphertext from the encrypter can be fed in as-is.
//
// Ports
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-low reset
//   start   : sampled in IDLE; high latches v and k and starts decryption
//   v       : ciphertext {z1, y1, z0, y0}, y0 in bits [31:0]
//   k       : key, k_reg[n] = k[32*n+31 : 32*n]
//   busy    : high from the cycle after acceptance until DONE completes
//   ready   : one-cycle pulse, data_o holds a fresh plaintext
//   data_o  : plaintext {z1, y1, z0, y0}
// ---------------------------------------------------------------------------
module xtea_dec #(
   parameter int unsigned ROUNDS = 32,
   parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] v,
   input  logic [127:0] k,
   output logic         busy,
   output logic         ready,
   output logic [127:0] data_o
);

   // Decryption walks the key schedule backwards, so sum starts at the value
   // the encrypter ends with (DELTA*ROUNDS, wrapped to 32 bits) and falls to 0.
   localparam logic [31:0] SUM_INIT   = DELTA * ROUNDS;
   localparam logic [5:0]  LAST_ROUND = 6'(ROUNDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      ZS,
      SUM,
      YS,
      DONE
   } state_t;

   state_t      state;
   logic [31:0] y0;
   logic [31:0] z0;
   logic [31:0] y1;
   logic [31:0] z1;
   logic [31:0] sum;
   logic [5:0]  i;
   logic [31:0] k_reg [4];
   logic [31:0] z_key;
   logic [31:0] y_key;

   // The XTEA mixing term ((x<<4) ^ (x>>5)) + x, shared by both half-steps
   // and both lanes.
   function automatic logic [31:0] mix(input logic [31:0] x);
      return ((x << 4) ^ (x >> 5)) + x;
   endfunction

   // Key word selection. The Z-step picks its word with bits 12:11 of sum
   // and the Y-step with bits 1:0. The Y-step runs after the SUM-step, so
   // it sees the already decremented sum, which is what decryption needs.
   assign z_key = k_reg[sum[12:11]];
   assign y_key = k_reg[sum[1:0]];

   // Main controller and datapath. Everything lives in one clocked block so
   // the outputs are registered and reset can abort an operation at any
   // point. ready defaults low every edge, which makes it a single pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         ready  <= 1'b0;
         data_o <= '0;
         y0     <= '0;
         z0     <= '0;
         y1     <= '0;
         z1     <= '0;
         sum    <= '0;
         i      <= '0;
         for (int n = 0; n < 4; n++) begin
            k_reg[n] <= '0;
         end
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  y0    <= v[31:0];
                  z0    <= v[63:32];
                  y1    <= v[95:64];
                  z1    <= v[127:96];
                  for (int n = 0; n < 4; n++) begin
                     k_reg[n] <= k[32*n +: 32];
                  end
                  sum   <= SUM_INIT;
                  i     <= '0;
                  busy  <= 1'b1;
                  state <= ZS;
               end
            end
            ZS: begin
               z0    <= z0 - (mix(y0) ^ (sum + z_key));
               z1    <= z1 - (mix(y1) ^ (sum + z_key));
               state <= SUM;
            end
            SUM: begin
               sum   <= sum - DELTA;
               state <= YS;
            end
            YS: begin
               y0    <= y0 - (mix(z0) ^ (sum + y_key));
               y1    <= y1 - (mix(z1) ^ (sum + y_key));
               i     <= i + 6'd1;
               state <= (i == LAST_ROUND) ? DONE : ZS;
            end
            DONE: begin
               data_o <= {z1, y1, z0, y0};
               ready  <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
